// File: rtl/noc_link_buffer.sv
// noc_link_buffer: registered VC-aware link stage between two routers.
// Per-VC FIFOs, round-robin output arbitration, occupancy and stall watchdog.
module noc_link_buffer #(
  parameter int FLIT_WIDTH  = 34,
  parameter int NUM_VC      = 3,
  parameter int BUF_DEPTH   = 2,
  parameter int STALL_LIMIT = 1024,
  localparam int VW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int CW = $clog2(BUF_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   in_valid_i,
  input  logic [FLIT_WIDTH-1:0]  in_fdata_i,
  input  logic [VW-1:0]          in_vc_id_i,
  output logic [NUM_VC-1:0]      in_ready_o,
  output logic                   out_valid_o,
  output logic [FLIT_WIDTH-1:0]  out_fdata_o,
  output logic [VW-1:0]          out_vc_id_o,
  input  logic [NUM_VC-1:0]      out_ready_i,
  output logic [NUM_VC*CW-1:0]   occ_o,
  output logic                   stall_o,
  output logic                   err_vc_o
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int SW = $clog2(STALL_LIMIT + 1);

  logic [FLIT_WIDTH-1:0] mem [NUM_VC][BUF_DEPTH];
  logic [PW-1:0]         rd_ptr [NUM_VC];
  logic [PW-1:0]         wr_ptr [NUM_VC];
  logic [CW-1:0]         occ [NUM_VC];
  logic [VW-1:0]         rr;
  logic [SW-1:0]         stall_cnt;
  logic [FLIT_WIDTH-1:0] hold_fdata;
  logic [VW-1:0]         hold_vc;
  logic                  err_vc;

  logic [NUM_VC-1:0]     nonempty;
  logic [NUM_VC-1:0]     full;
  logic [NUM_VC-1:0]     eligible;
  logic [NUM_VC-1:0]     push;
  logic [NUM_VC-1:0]     pop;
  logic                  vc_ok;
  logic                  found;
  logic [VW-1:0]         grant;
  logic [VW-1:0]         next_rr;
  logic [FLIT_WIDTH-1:0] head;

  assign vc_ok = 32'(in_vc_id_i) < NUM_VC;

  // Ready is a function of stored occupancy only, never of in_valid_i.
  always_comb begin
    nonempty   = '0;
    full       = '0;
    eligible   = '0;
    push       = '0;
    in_ready_o = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      nonempty[v]   = occ[v] != '0;
      full[v]       = occ[v] == CW'(BUF_DEPTH);
      eligible[v]   = nonempty[v] && out_ready_i[v];
      in_ready_o[v] = !full[v];
      push[v]       = in_valid_i && vc_ok &&
                      (32'(in_vc_id_i) == v) && !full[v];
    end
  end

  // First eligible VC at or after the round-robin pointer.
  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (!found && eligible[(32'(rr) + i) % NUM_VC]) begin
        found = 1'b1;
        grant = VW'((32'(rr) + i) % NUM_VC);
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      pop[v] = found && (32'(grant) == v);
    end
  end

  assign next_rr = (32'(grant) == NUM_VC - 1) ? '0 : grant + 1'b1;
  assign head    = mem[grant][rd_ptr[grant]];

  assign out_valid_o = found;
  assign out_fdata_o = found ? head : hold_fdata;
  assign out_vc_id_o = found ? grant : hold_vc;
  assign stall_o     = stall_cnt >= SW'(STALL_LIMIT);
  assign err_vc_o    = err_vc;

  always_comb begin
    occ_o = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      occ_o[v*CW +: CW] = occ[v];
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (push[v]) mem[v][wr_ptr[v]] <= in_fdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        rd_ptr[v] <= '0;
        wr_ptr[v] <= '0;
        occ[v]    <= '0;
      end
      rr         <= '0;
      stall_cnt  <= '0;
      hold_fdata <= '0;
      hold_vc    <= '0;
      err_vc     <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (push[v]) wr_ptr[v] <= wr_ptr[v] + 1'b1;
        if (pop[v])  rd_ptr[v] <= rd_ptr[v] + 1'b1;
        if (push[v] && !pop[v])      occ[v] <= occ[v] + 1'b1;
        else if (!push[v] && pop[v]) occ[v] <= occ[v] - 1'b1;
      end
      if (found) begin
        rr         <= next_rr;
        hold_fdata <= head;
        hold_vc    <= grant;
      end
      if (in_valid_i && !vc_ok) err_vc <= 1'b1;
      if (found || !(|nonempty)) begin
        stall_cnt <= '0;
      end else if (stall_cnt < SW'(STALL_LIMIT)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_noc_link_buffer.sv
// tb_noc_link_buffer: random + directed stimulus against a queue-level
// model; a negedge monitor pops per-cycle expectations and compares.
module tb_noc_link_buffer;

  localparam int FW = 34;
  localparam int NV = 3;
  localparam int BD = 2;
  localparam int SL = 1024;
  localparam int VW = 2;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          arst;
  logic          in_valid_i;
  logic [FW-1:0] in_fdata_i;
  logic [VW-1:0] in_vc_id_i;
  logic [NV-1:0] in_ready_o;
  logic          out_valid_o;
  logic [FW-1:0] out_fdata_o;
  logic [VW-1:0] out_vc_id_o;
  logic [NV-1:0] out_ready_i;
  logic [NV*CW-1:0] occ_o;
  logic          stall_o;
  logic          err_vc_o;

  always #5 clk = ~clk;

  noc_link_buffer #(
    .FLIT_WIDTH(FW), .NUM_VC(NV), .BUF_DEPTH(BD), .STALL_LIMIT(SL)
  ) dut (
    .clk(clk), .arst(arst),
    .in_valid_i(in_valid_i), .in_fdata_i(in_fdata_i),
    .in_vc_id_i(in_vc_id_i), .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o), .out_fdata_o(out_fdata_o),
    .out_vc_id_o(out_vc_id_o), .out_ready_i(out_ready_i),
    .occ_o(occ_o), .stall_o(stall_o), .err_vc_o(err_vc_o)
  );

  typedef struct packed {
    logic          valid;
    logic [VW-1:0] vc;
    logic [FW-1:0] data;
    logic [NV*CW-1:0] occ;
    logic [NV-1:0] rdy;
    logic          stall;
    logic          err;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int n_checks = 0;
  int n_fail = 0;

  // Reference model: per-VC arrays used as shift queues.
  int            m_cnt [NV];
  logic [FW-1:0] m_buf [NV][BD];
  int            m_rr;
  int            m_stall;
  bit            m_err;
  logic [FW-1:0] m_last_d;
  int            m_last_vc;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) m_cnt[v] = 0;
    m_rr = 0;
    m_stall = 0;
    m_err = 0;
    m_last_d = '0;
    m_last_vc = 0;
  endtask

  task automatic cycle(input bit rst, input bit inv, input int vc,
                       input logic [FW-1:0] d, input logic [NV-1:0] rdy);
    exp_t e;
    bit found, any, accept;
    int g, k;
    arst = rst;
    in_valid_i = inv;
    in_vc_id_i = vc[VW-1:0];
    in_fdata_i = d;
    out_ready_i = rdy;
    found = 0;
    g = 0;
    for (int i = 0; i < NV; i++) begin
      k = (m_rr + i) % NV;
      if (!found && m_cnt[k] > 0 && rdy[k]) begin
        found = 1;
        g = k;
      end
    end
    e = '0;
    e.valid = found;
    e.vc = found ? g[VW-1:0] : m_last_vc[VW-1:0];
    e.data = found ? m_buf[g][0] : m_last_d;
    for (int v = 0; v < NV; v++) begin
      e.occ[v*CW +: CW] = m_cnt[v][CW-1:0];
      e.rdy[v] = (m_cnt[v] != BD);
    end
    e.stall = (m_stall >= SL);
    e.err = m_err;
    expq.push_back(e);
    if (rst) begin
      model_reset();
    end else begin
      any = 0;
      for (int v = 0; v < NV; v++) any |= (m_cnt[v] > 0);
      if (found || !any) m_stall = 0;
      else if (m_stall < SL) m_stall++;
      if (inv && vc >= NV) m_err = 1;
      accept = inv && vc < NV && m_cnt[vc] < BD;
      if (found) begin
        m_last_d = m_buf[g][0];
        m_last_vc = g;
        for (int j = 0; j < BD - 1; j++) m_buf[g][j] = m_buf[g][j+1];
        m_cnt[g]--;
        m_rr = (g + 1) % NV;
      end
      if (accept) begin
        m_buf[vc][m_cnt[vc]] = d;
        m_cnt[vc]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] rnd();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[FW-1:0];
  endfunction

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      mon_e = expq.pop_front();
      chk("out_valid", 64'(out_valid_o), 64'(mon_e.valid));
      chk("out_vc_id", 64'(out_vc_id_o), 64'(mon_e.vc));
      chk("out_fdata", 64'(out_fdata_o), 64'(mon_e.data));
      chk("occ", 64'(occ_o), 64'(mon_e.occ));
      chk("in_ready", 64'(in_ready_o), 64'(mon_e.rdy));
      chk("stall", 64'(stall_o), 64'(mon_e.stall));
      chk("err_vc", 64'(err_vc_o), 64'(mon_e.err));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    arst = 1'b1;
    in_valid_i = 1'b0;
    in_fdata_i = '0;
    in_vc_id_i = '0;
    out_ready_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;

    // single flit on VC1
    cycle(0, 1, 1, 34'h2_AAAA_5555, 3'b111);
    repeat (3) cycle(0, 0, 0, '0, 3'b111);

    // fill VC0 with ready low, third flit refused, then drain
    cycle(0, 1, 0, rnd(), 3'b000);
    cycle(0, 1, 0, rnd(), 3'b000);
    cycle(0, 1, 0, rnd(), 3'b000);
    repeat (3) cycle(0, 0, 0, '0, 3'b111);

    // fill all VCs, drain round-robin
    for (int v = 0; v < NV; v++)
      for (int i = 0; i < BD; i++) cycle(0, 1, v, rnd(), 3'b000);
    repeat (8) cycle(0, 0, 0, '0, 3'b111);

    // VC2 blocked while VC0 streams, then watchdog runs out
    cycle(0, 1, 2, rnd(), 3'b000);
    cycle(0, 1, 2, rnd(), 3'b000);
    repeat (20) cycle(0, 1, 0, rnd(), 3'b011);
    repeat (SL + 5) cycle(0, 0, 0, '0, 3'b011);

    // illegal VC is dropped and flagged
    cycle(0, 1, 3, rnd(), 3'b011);
    repeat (4) cycle(0, 0, 0, '0, 3'b011);

    // reset with four flits buffered
    cycle(0, 1, 0, rnd(), 3'b000);
    cycle(0, 1, 0, rnd(), 3'b000);
    cycle(1, 0, 0, '0, 3'b000);
    repeat (3) cycle(0, 0, 0, '0, 3'b111);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 299) == 0,
            $urandom_range(0, 3) != 0,
            ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2)),
            rnd(),
            3'($urandom_range(0, 7)));
    end
    cycle(0, 0, 0, '0, 3'b111);

    chk("drain", 64'(expq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
